// File: rtl/spi_coproc_sched.sv
// ============================================================================
// Module   : spi_coproc_sched
// Brief    : SPI master/scheduler routing one decoded operation at a time to
//            the alu/mul/bas SPI coprocessors and returning the 32-bit result.
//            Optional macro SPI_SCHED_TIMEOUT_EN: slave-ready polling + timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_coproc_sched #(
  parameter int CLK_DIV  = 2,
  parameter int TURN_CYC = 4
`ifdef SPI_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = 255
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic        req_imm,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic [2:0]  nss
);

  localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

  localparam logic [6:0] c_TX_LAST = 7'd71;
  localparam logic [6:0] c_RX_LAST = 7'd31;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_TX    = 3'd2;
`ifndef SPI_SCHED_TIMEOUT_EN
  localparam logic [2:0] S_TURN  = 3'd3;
`endif
  localparam logic [2:0] S_RX    = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
`ifdef SPI_SCHED_TIMEOUT_EN
  localparam logic [2:0] S_WAIT  = 3'd7;

  localparam int c_TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
`else
  localparam int c_TURN_N = TURN_CYC * 2 * CLK_DIV;
  localparam int c_TURN_W = (c_TURN_N > 1) ? $clog2(c_TURN_N) : 1;
  localparam logic [c_TURN_W-1:0] c_TURN_LAST = c_TURN_W'(c_TURN_N - 1);
`endif

  logic [2:0]         r_state;
  logic [c_DIV_W-1:0] r_div;
  logic [6:0]         r_bit;
  logic               r_sclk;
  logic [71:0]        r_tx;
  logic [31:0]        r_rx;
  logic [2:0]         r_sel;
`ifdef SPI_SCHED_TIMEOUT_EN
  logic [c_TMO_W-1:0] r_tmo;
  logic               r_rdy;
  logic               r_err;
`else
  logic [c_TURN_W-1:0] r_turn;
`endif

  logic       w_div_end;
  logic       w_active;
  logic [2:0] w_sel;

  assign w_div_end = (r_div == c_DIV_LAST);

  // One-hot target select: bit 0 = alu, bit 1 = mul, bit 2 = bas
  always_comb begin
    w_sel = 3'b001;
    case (req_op)
      3'd3:       w_sel = 3'b010;
      3'd4, 3'd5: w_sel = 3'b100;
      default:    w_sel = 3'b001;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_sclk  <= 1'b0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_sel   <= 3'b000;
`ifdef SPI_SCHED_TIMEOUT_EN
      r_tmo   <= '0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
`else
      r_turn  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_div  <= '0;
          r_bit  <= '0;
          r_sclk <= 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
          r_tmo  <= '0;
          r_rdy  <= 1'b0;
`endif
          if (req_valid) begin
            r_tx    <= {req_op, req_imm, 4'b0000, req_a, req_b};
            r_sel   <= w_sel;
            r_state <= S_SETUP;
`ifdef SPI_SCHED_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
          end
        end

        S_SETUP: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= S_TX;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        // Each bit period is CLK_DIV cycles low then CLK_DIV high; shift on fall
        S_TX: begin
          if (w_div_end) begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              r_sclk <= 1'b0;
              r_tx   <= {r_tx[70:0], 1'b0};
              if (r_bit == c_TX_LAST) begin
                r_bit <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
                r_state <= S_WAIT;
`else
                r_state <= S_TURN;
`endif
              end else begin
                r_bit <= r_bit + 1'b1;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

`ifdef SPI_SCHED_TIMEOUT_EN
        // Poll the slave ready bit on each rising sclk until it reads 1
        S_WAIT: begin
          if (r_tmo == c_TMO_LAST) begin
            r_tmo   <= '0;
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_rdy   <= 1'b0;
            r_rx    <= '0;
            r_err   <= 1'b1;
            r_state <= S_HOLD;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if (w_div_end) begin
              r_div <= '0;
              if (!r_sclk) begin
                r_sclk <= 1'b1;
                r_rdy  <= miso;
              end else begin
                r_sclk <= 1'b0;
                if (r_rdy) begin
                  r_rdy   <= 1'b0;
                  r_bit   <= '0;
                  r_state <= S_RX;
                end
              end
            end else begin
              r_div <= r_div + 1'b1;
            end
          end
        end
`else
        S_TURN: begin
          if (r_turn == c_TURN_LAST) begin
            r_turn  <= '0;
            r_div   <= '0;
            r_state <= S_RX;
          end else begin
            r_turn <= r_turn + 1'b1;
          end
        end
`endif

        S_RX: begin
          if (w_div_end) begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              r_rx   <= {r_rx[30:0], miso};
            end else begin
              r_sclk <= 1'b0;
              if (r_bit == c_RX_LAST) begin
                r_bit   <= '0;
                r_state <= S_HOLD;
              end else begin
                r_bit <= r_bit + 1'b1;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        S_HOLD: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= S_DONE;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        S_DONE: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_active = 1'b0;
    case (r_state)
      S_SETUP, S_TX, S_RX: w_active = 1'b1;
`ifdef SPI_SCHED_TIMEOUT_EN
      S_WAIT:              w_active = 1'b1;
`else
      S_TURN:              w_active = 1'b1;
`endif
      default:             w_active = 1'b0;
    endcase
  end

  assign nss       = w_active ? ~r_sel : 3'b111;
  assign sclk      = r_sclk;
  assign mosi      = ((r_state == S_SETUP) || (r_state == S_TX)) ? r_tx[71] : 1'b0;
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_data  = r_rx;
`ifdef SPI_SCHED_TIMEOUT_EN
  assign rsp_err   = r_err;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

`default_nettype wire
